if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF/ID pipeline register for the MIPS-32 core. It sits between instruction fetch and decode and captures the fetched instruction word together with its PC. It applies an optional byte-order reversal and decouples the two stages with a ready/valid handshake and a 2-entry skid buffer. This lets decode stall, and lets a taken branch or jump flush the stage, without losing or duplicating instructions.

## Interface
- `DATA_W`, 32, instruction width in bits; must be a multiple of 8, 8..64.
- `PC_W`, 32, PC width in bits.
- `SWAP_BYTES`, 1, 1 = reverse byte order of `in_instr` on capture (little-endian memory to MIPS order); 0 = pass unchanged.
- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept; transfer when `in_valid && in_ready`.
- `in_instr` input DATA_W: raw fetched word.
- `in_pc` input PC_W: PC of `in_instr`.
- `flush` input 1: discard all held and incoming instructions.
- `out_valid` output 1: decode has a valid instruction.
- `out_ready` input 1: decode consumes; transfer when `out_valid && out_ready`.
- `out_instr` output DATA_W: byte-ordered instruction.
- `out_pc` output PC_W: PC of `out_instr`.
- `stall_count` output 16: present only with `IF_ID_STALL_CNT_EN`.

## Operation
- Storage: main entry (drives outputs) plus skid entry; each has instr, pc and valid.
- Byte order: with `SWAP_BYTES=1`, byte k of the stored word = byte (DATA_W/8-1-k) of `in_instr`. Reordering happens at capture, never at output.
- States: EMPTY (no valid entry), ONE (main valid), FULL (main and skid valid).
- EMPTY: input accept -> ONE.
- ONE, output taken, no accept -> EMPTY.
- ONE, output taken and accept -> ONE (new word in main).
- ONE, output not taken and accept -> FULL (new word in skid).
- FULL, output taken -> ONE (skid moves to main); no input is accepted in FULL.
- `in_ready` = not FULL. It is a registered function of state and does not depend combinationally on `out_ready`.
- `out_valid` = state != EMPTY; `out_instr`/`out_pc` come from registers only.
- Flush: at the next edge, state -> EMPTY and both valids clear. Flush has priority over a simultaneous input accept (that word is dropped) and over a simultaneous output transfer (that transfer still counts as consumed by decode in that cycle). Data registers hold their old contents on flush.
- Order is strictly preserved; no word is duplicated or lost outside flush.

## Timing
- Reset (async assert, synchronous-to-clock deassert by the system): state EMPTY, `out_valid`=0, `in_ready`=1, `out_instr`=0 (MIPS NOP), `out_pc`=0, `stall_count`=0.
- Latency: a word accepted at edge N is on outputs with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle while `out_ready`=1.
- `in_ready` falls the cycle after entering FULL and rises the cycle after leaving it.
- Reset mid-transfer wins over everything; held words are discarded.

## Configuration
- `IF_ID_STALL_CNT_EN` defined: adds `stall_count`, a 16-bit counter incremented every cycle `out_valid && !out_ready`. It saturates at 0xFFFF and is cleared by reset only, not by flush.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `if_id_pkg`: state enum (EMPTY/ONE/FULL), `NOP_INSTR` constant (32'h0000_0000), default `DATA_W`/`PC_W`.
- One sub-module: `byte_swap` (parametrised by `DATA_W`, combinational byte reversal), instantiated on the capture path under `SWAP_BYTES`.

## Test plan
- Reset, then `in_instr`=32'h2001_0005, `in_pc`=0x0, `SWAP_BYTES`=1, `out_ready`=1 -> next cycle `out_valid`=1, `out_instr`=32'h0500_0120, `out_pc`=0.
- Stream 4 words back-to-back with `out_ready`=1 -> 4 consecutive output cycles in order, `in_ready` constantly 1.
- Accept A, B with `out_ready`=0 -> FULL, `in_ready`=0, output holds A; raise `out_ready` -> A, B emitted on successive cycles, `in_ready` returns to 1.
- FULL plus `flush` together with `in_valid`=1 -> next cycle `out_valid`=0, incoming word dropped, next accepted word is output with correct PC.
- Async `reset_n` low mid-stream -> outputs immediately 0/NOP, `in_ready`=1; with `IF_ID_STALL_CNT_EN`, 10 stalled cycles give `stall_count`=10, flush leaves it at 10, reset clears it.

Source files
------------

// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pkg
// Purpose  : Shared types and constants for the IF/ID skid pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } if_id_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_PC_W   = 32;

endpackage
`default_nettype wire

// File: rtl/if_id_skid_reg_byte_swap.sv
`default_nettype none
// ============================================================================
// Module   : byte_swap
// Purpose  : Combinational byte-order reversal of a DATA_W-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module byte_swap
    import if_id_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int c_NBYTES = DATA_W / 8;

    for (genvar k = 0; k < c_NBYTES; k++) begin : g_byte
        assign o_data[8*k +: 8] = i_data[8*(c_NBYTES-1-k) +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid_reg
// Purpose  : IF/ID pipeline register with 2-entry skid buffer, flush and
//            optional capture-side byte swap. IF_ID_STALL_CNT_EN adds a
//            saturating decode-stall counter output.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PC_W       = DEF_PC_W,
    parameter int SWAP_BYTES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam logic [DATA_W-1:0] c_NOP = DATA_W'(NOP_INSTR);

    if_id_state_e      r_state;
    if_id_state_e      w_state_nxt;
    logic [DATA_W-1:0] w_cap_instr;
    logic [DATA_W-1:0] r_main_instr;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_skid_instr;
    logic [PC_W-1:0]   r_skid_pc;
    logic              w_accept;
    logic              w_take;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    if (SWAP_BYTES != 0) begin : g_swap
        byte_swap #(.DATA_W(DATA_W)) u_byte_swap (
            .i_data (in_instr),
            .o_data (w_cap_instr)
        );
    end else begin : g_noswap
        assign w_cap_instr = in_instr;
    end

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
    assign w_accept  = in_valid && in_ready;
    assign w_take    = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_EMPTY;
        else          r_state <= w_state_nxt;
    end

    // Flush overrides every transition and suppresses all data loads.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_take && w_accept) begin
                        w_load_main = 1'b1;
                    end else if (w_take) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_take) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_main_instr <= c_NOP;
            r_main_pc    <= '0;
            r_skid_instr <= c_NOP;
            r_skid_pc    <= '0;
        end else begin
            if (w_load_main) begin
                r_main_instr <= w_main_from_skid ? r_skid_instr : w_cap_instr;
                r_main_pc    <= w_main_from_skid ? r_skid_pc    : in_pc;
            end
            if (w_load_skid) begin
                r_skid_instr <= w_cap_instr;
                r_skid_pc    <= in_pc;
            end
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_stall_cnt <= '0;
        else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_skid_reg
// Purpose  : Self-checking bench for if_id_skid_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int     n_vec = 0;
    int     n_err = 0;
    entry_t model_q[$];
    int     model_stall = 0;

    always #5 clock = ~clock;

    if_id_skid_reg #(.DATA_W(32), .PC_W(32), .SWAP_BYTES(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    function automatic logic [31:0] swap32(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            chk("out_instr", 64'(out_instr), 64'(model_q[0].instr));
            chk("out_pc", 64'(out_pc), 64'(model_q[0].pc));
        end
`ifdef IF_ID_STALL_CNT_EN
        chk("stall_count", 64'(stall_count), 64'(model_stall));
`endif
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy);
        bit acc, take;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        acc  = iv && (model_q.size() < 2);
        take = (model_q.size() > 0) && ordy;
        if (model_q.size() > 0 && !ordy && model_stall < 65535) model_stall++;
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            if (take) void'(model_q.pop_front());
            if (acc) model_q.push_back('{instr: swap32(ins), pc: pc});
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_q.delete();
        model_stall = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_out_pc", 64'(out_pc), 64'h0);
`ifdef IF_ID_STALL_CNT_EN
        chk("rst_stall", 64'(stall_count), 64'd0);
`endif

        // Single word, byte-swapped.
        step(1'b1, 32'h2001_0005, 32'h0, 1'b0, 1'b1);
        chk("swap_instr", 64'(out_instr), 64'h0500_0120);
        chk("swap_valid", 64'(out_valid), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Back-to-back stream.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1111_0000 + 32'(i), 32'h100 + 32'(4*i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Fill the skid with decode stalled, then drain.
        step(1'b1, 32'hAAAA_0001, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 32'h204, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_hold_a", 64'(out_instr), 64'(swap32(32'hAAAA_0001)));
        step(1'b1, 32'hCCCC_0003, 32'h208, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("drain_b", 64'(out_pc), 64'h204);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush while full with an incoming word.
        step(1'b1, 32'hDDDD_0004, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'hEEEE_0005, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_0006, 32'h308, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h1234_5678, 32'h400, 1'b1, 1'b1);
        step(1'b1, 32'h8765_4321, 32'h404, 1'b0, 1'b0);
        chk("post_flush_pc", 64'(out_pc), 64'h404);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Async reset mid-stream.
        step(1'b1, 32'h0BAD_F00D, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h0BAD_F00E, 32'h504, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_instr", 64'(out_instr), 64'h0);
        chk("arst_pc", 64'(out_pc), 64'h0);
        model_q.delete();
        model_stall = 0;
        @(negedge clock);
        reset_n = 1'b1;

        // Ten stalled cycles, then a consuming flush.
        step(1'b1, 32'h0000_0600, 32'h600, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef IF_ID_STALL_CNT_EN
        chk("stall_10", 64'(stall_count), 64'd10);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
        chk("stall_after_flush", 64'(stall_count), 64'd10);
`endif
        do_reset();
        check_outputs();

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
